// File: rtl/md_unit_ctrl.sv
// HI/LO multiply/divide sequencer for the E stage: accepts md ops, holds the result
// in pending registers for a fixed latency, then commits to HI/LO while stalling D users.
module md_unit_ctrl #(
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned DIV_LAT = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_E,
   input  logic [2:0]  md_op_E,
   input  logic [31:0] rs_E,
   input  logic [31:0] rt_E,
   input  logic        md_use_D,
   output logic        busy,
   output logic        stall_D,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
   localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [31:0] pend_hi_reg, pend_hi_next;
   logic [31:0] pend_lo_reg, pend_lo_next;
   logic [31:0] hi_reg, hi_next;
   logic [31:0] lo_reg, lo_next;

   logic [63:0] prod_s, prod_u;
   logic [31:0] divu_den, divs_den;
   logic [31:0] quot_s, rem_s, quot_u, rem_u;
   logic        div_ovf;

   assign prod_s = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});
   assign prod_u = {32'd0, rs_E} * {32'd0, rt_E};

   // Zero divisors are swapped for 1 so the datapath never yields X; that result is
   // discarded anyway. MIN/-1 divides by 1 instead, which gives exactly LO=MIN, HI=0.
   assign div_ovf  = (rs_E == 32'h8000_0000) && (rt_E == 32'hFFFF_FFFF);
   assign divu_den = (rt_E == 32'd0) ? 32'd1 : rt_E;
   assign divs_den = div_ovf ? 32'd1 : divu_den;
   assign quot_s   = $signed(rs_E) / $signed(divs_den);
   assign rem_s    = $signed(rs_E) % $signed(divs_den);
   assign quot_u   = rs_E / divu_den;
   assign rem_u    = rs_E % divu_den;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= 4'd0;
         pend_hi_reg <= 32'd0;
         pend_lo_reg <= 32'd0;
         hi_reg      <= 32'd0;
         lo_reg      <= 32'd0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         pend_hi_reg <= pend_hi_next;
         pend_lo_reg <= pend_lo_next;
         hi_reg      <= hi_next;
         lo_reg      <= lo_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      pend_hi_next = pend_hi_reg;
      pend_lo_next = pend_lo_reg;
      hi_next      = hi_reg;
      lo_next      = lo_reg;
      case (state_reg)
         IDLE: begin
            if (start_E) begin
               case (md_op_E)
                  OP_MULT, OP_MULTU: begin
                     {pend_hi_next, pend_lo_next} = (md_op_E == OP_MULT) ? prod_s : prod_u;
                     cnt_next   = MUL_CNT;
                     state_next = BUSY;
                  end
                  OP_DIV, OP_DIVU: begin
                     if (rt_E == 32'd0) begin
                        pend_hi_next = hi_reg;
                        pend_lo_next = lo_reg;
                     end else if (md_op_E == OP_DIV) begin
                        pend_hi_next = rem_s;
                        pend_lo_next = quot_s;
                     end else begin
                        pend_hi_next = rem_u;
                        pend_lo_next = quot_u;
                     end
                     cnt_next   = DIV_CNT;
                     state_next = BUSY;
                  end
                  OP_MTHI: hi_next = rs_E;
                  OP_MTLO: lo_next = rs_E;
                  default: ;
               endcase
            end
         end
         BUSY: begin
            if (cnt_reg == 4'd1) begin
               hi_next    = pend_hi_reg;
               lo_next    = pend_lo_reg;
               cnt_next   = 4'd0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy    = (state_reg == BUSY);
   assign stall_D = md_use_D & (busy | start_E);
   assign hi_o    = hi_reg;
   assign lo_o    = lo_reg;

endmodule
